// File: rtl/seven_seg_pkg.sv
// Shared seven-segment definitions: active-high {a..g} glyph patterns, decode/encode
// helpers and the scan-decoder state type, used by both the driver and the monitor.
package seven_seg_pkg;

    localparam logic [6:0] SEG_0 = 7'b1111110;
    localparam logic [6:0] SEG_1 = 7'b0110000;
    localparam logic [6:0] SEG_2 = 7'b1101101;
    localparam logic [6:0] SEG_3 = 7'b1111001;
    localparam logic [6:0] SEG_4 = 7'b0110011;
    localparam logic [6:0] SEG_5 = 7'b1011011;
    localparam logic [6:0] SEG_6 = 7'b1011111;
    localparam logic [6:0] SEG_7 = 7'b1110000;
    localparam logic [6:0] SEG_8 = 7'b1111111;
    localparam logic [6:0] SEG_9 = 7'b1111011;
    localparam logic [6:0] SEG_A = 7'b1110111;
    localparam logic [6:0] SEG_B = 7'b0011111;
    localparam logic [6:0] SEG_C = 7'b1001110;
    localparam logic [6:0] SEG_D = 7'b0111101;
    localparam logic [6:0] SEG_E = 7'b1001111;
    localparam logic [6:0] SEG_F = 7'b1000111;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        CAPTURED
    } scan_state_t;

    typedef struct packed {
        logic       valid;
        logic [3:0] value;
    } seg_decode_t;

    // Unknown glyphs decode to 0 with valid cleared so the caller can flag them.
    function automatic seg_decode_t seg_decode(input logic [6:0] pattern);
        seg_decode_t r;
        r.valid = 1'b1;
        r.value = 4'h0;
        case (pattern)
            SEG_0: r.value = 4'h0;
            SEG_1: r.value = 4'h1;
            SEG_2: r.value = 4'h2;
            SEG_3: r.value = 4'h3;
            SEG_4: r.value = 4'h4;
            SEG_5: r.value = 4'h5;
            SEG_6: r.value = 4'h6;
            SEG_7: r.value = 4'h7;
            SEG_8: r.value = 4'h8;
            SEG_9: r.value = 4'h9;
            SEG_A: r.value = 4'hA;
            SEG_B: r.value = 4'hB;
            SEG_C: r.value = 4'hC;
            SEG_D: r.value = 4'hD;
            SEG_E: r.value = 4'hE;
            SEG_F: r.value = 4'hF;
            default: r.valid = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic [6:0] seg_encode(input logic [3:0] value);
        case (value)
            4'h0: return SEG_0;
            4'h1: return SEG_1;
            4'h2: return SEG_2;
            4'h3: return SEG_3;
            4'h4: return SEG_4;
            4'h5: return SEG_5;
            4'h6: return SEG_6;
            4'h7: return SEG_7;
            4'h8: return SEG_8;
            4'h9: return SEG_9;
            4'hA: return SEG_A;
            4'hB: return SEG_B;
            4'hC: return SEG_C;
            4'hD: return SEG_D;
            4'hE: return SEG_E;
            default: return SEG_F;
        endcase
    endfunction

    // Anode strobes are active-low; a digit is being shown only when exactly one is low.
    function automatic logic onehot_low(input logic [3:0] an);
        case (an)
            4'b1110, 4'b1101, 4'b1011, 4'b0111: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [1:0] low_index(input logic [3:0] an);
        case (an)
            4'b1101: return 2'd1;
            4'b1011: return 2'd2;
            4'b0111: return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/seg_pattern_decode.sv
// Combinational glyph decoder: active-high {a..g} pattern to hex value plus a valid flag.
module seg_pattern_decode
    import seven_seg_pkg::*;
(
    input  logic [6:0] pattern,
    output logic       valid,
    output logic [3:0] value
);

    seg_decode_t dec;

    always_comb begin
        dec = seg_decode(pattern);
    end

    assign valid = dec.valid;
    assign value = dec.value;

endmodule

// File: rtl/seven_seg_scan_decoder.sv
// Monitor for a four-digit multiplexed LED driver: waits for each strobe to settle,
// decodes the glyph into a per-position shadow slot and publishes whole frames.
module seven_seg_scan_decoder
    import seven_seg_pkg::*;
#(
    parameter int STABLE_CYCLES = 16,
    parameter int CNT_W         = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       an3,
    input  logic       an2,
    input  logic       an1,
    input  logic       an0,
    input  logic       a,
    input  logic       b,
    input  logic       c,
    input  logic       d,
    input  logic       e,
    input  logic       f,
    input  logic       g,
    input  logic       dp,
    output logic [3:0] digit3,
    output logic [3:0] digit2,
    output logic [3:0] digit1,
    output logic [3:0] digit0,
    output logic [3:0] dp_out,
    output logic [3:0] err_out,
    output logic       frame_valid
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic [3:0] an_reg;
    logic [3:0] an_prev_reg;
    logic [6:0] seg_reg;
    logic [6:0] seg_prev_reg;
    logic       dp_reg;
    logic       dp_prev_reg;

    // Pins are active-low; the registered copy of the segments is active-high.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            an_reg       <= 4'b1111;
            an_prev_reg  <= 4'b1111;
            seg_reg      <= '0;
            seg_prev_reg <= '0;
            dp_reg       <= 1'b0;
            dp_prev_reg  <= 1'b0;
        end else begin
            an_reg       <= {an3, an2, an1, an0};
            seg_reg      <= ~{a, b, c, d, e, f, g};
            dp_reg       <= ~dp;
            an_prev_reg  <= an_reg;
            seg_prev_reg <= seg_reg;
            dp_prev_reg  <= dp_reg;
        end
    end

    logic       changed;
    logic       one_hot;
    logic [1:0] active_idx;
    logic       sample_now;

    assign changed    = (an_reg != an_prev_reg) || (seg_reg != seg_prev_reg)
                        || (dp_reg != dp_prev_reg);
    assign one_hot    = onehot_low(an_reg);
    assign active_idx = low_index(an_reg);

    scan_state_t      state_reg;
    logic [CNT_W-1:0] cnt_reg;

    assign sample_now = (state_reg == SETTLE) && !changed && (cnt_reg == CNT_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    cnt_reg <= '0;
                    if (one_hot) begin
                        state_reg <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (changed) begin
                        cnt_reg   <= '0;
                        state_reg <= one_hot ? SETTLE : IDLE;
                    end else if (cnt_reg == CNT_LAST) begin
                        state_reg <= CAPTURED;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                CAPTURED: begin
                    // Counter stays parked at its last value until the inputs move.
                    if (changed) begin
                        cnt_reg   <= '0;
                        state_reg <= one_hot ? SETTLE : IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    cnt_reg   <= '0;
                end
            endcase
        end
    end

    logic       dec_valid;
    logic [3:0] dec_value;

    seg_pattern_decode u_decode (
        .pattern (seg_reg),
        .valid   (dec_valid),
        .value   (dec_value)
    );

    logic       frame_pending_reg;
    logic [3:0] slot_val [4];
    logic [3:0] slot_dp;
    logic [3:0] slot_err;
    logic [3:0] seen;

    for (genvar gi = 0; gi < 4; gi++) begin : g_slot
        logic [3:0] val_reg;
        logic       dp_bit_reg;
        logic       err_bit_reg;
        logic       seen_reg;

        // A later sample of the same position simply overwrites the slot.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                val_reg     <= '0;
                dp_bit_reg  <= 1'b0;
                err_bit_reg <= 1'b0;
                seen_reg    <= 1'b0;
            end else begin
                if (frame_pending_reg) begin
                    seen_reg <= 1'b0;
                end
                if (sample_now && (active_idx == 2'(gi))) begin
                    val_reg     <= dec_value;
                    dp_bit_reg  <= dp_reg;
                    err_bit_reg <= !dec_valid;
                    seen_reg    <= 1'b1;
                end
            end
        end

        assign slot_val[gi] = val_reg;
        assign slot_dp[gi]  = dp_bit_reg;
        assign slot_err[gi] = err_bit_reg;
        assign seen[gi]     = seen_reg;
    end

    logic [3:0] seen_eff;
    logic       completes;

    assign seen_eff  = frame_pending_reg ? 4'b0000 : seen;
    assign completes = sample_now && ((seen_eff | (4'b0001 << active_idx)) == 4'b1111);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_pending_reg <= 1'b0;
            frame_valid       <= 1'b0;
            digit3            <= '0;
            digit2            <= '0;
            digit1            <= '0;
            digit0            <= '0;
            dp_out            <= '0;
            err_out           <= '0;
        end else begin
            frame_pending_reg <= completes;
            frame_valid       <= frame_pending_reg;
            if (frame_pending_reg) begin
                digit3  <= slot_val[3];
                digit2  <= slot_val[2];
                digit1  <= slot_val[1];
                digit0  <= slot_val[0];
                dp_out  <= slot_dp;
                err_out <= slot_err;
            end
        end
    end

endmodule

// File: tb/tb_seven_seg_scan_decoder.sv
// Bench for seven_seg_scan_decoder: directed scenarios plus random strobe/segment holds,
// each frame checked against an independent capture/frame model.
module tb_seven_seg_scan_decoder;

    localparam int S = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       an3 = 1'b1, an2 = 1'b1, an1 = 1'b1, an0 = 1'b1;
    logic       a = 1'b1, b = 1'b1, c = 1'b1, d = 1'b1, e = 1'b1, f = 1'b1, g = 1'b1;
    logic       dp = 1'b1;
    logic [3:0] digit3, digit2, digit1, digit0, dp_out, err_out;
    logic       frame_valid;

    always #5 clk = ~clk;

    seven_seg_scan_decoder #(.STABLE_CYCLES(S), .CNT_W(8)) dut (
        .clk(clk), .reset(reset),
        .an3(an3), .an2(an2), .an1(an1), .an0(an0),
        .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g), .dp(dp),
        .digit3(digit3), .digit2(digit2), .digit1(digit1), .digit0(digit0),
        .dp_out(dp_out), .err_out(err_out), .frame_valid(frame_valid)
    );

    typedef struct {
        logic [15:0] digs;
        logic [3:0]  dps;
        logic [3:0]  errs;
    } frame_t;

    logic [6:0] tbl [16] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
        7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
        7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
        7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
    };

    int         n_cmp = 0;
    int         n_err = 0;
    int         n_frames = 0;
    bit         mon_en = 1'b0;
    frame_t     exp_q[$];
    frame_t     last_fr = '{16'h0, 4'h0, 4'h0};

    logic [3:0] m_seen = '0;
    logic [3:0] m_val [4] = '{4'h0, 4'h0, 4'h0, 4'h0};
    logic [3:0] m_dp = '0;
    logic [3:0] m_err = '0;
    logic [3:0] cur_an = 4'hF;
    logic [6:0] cur_pat = '0;
    logic       cur_dp = 1'b0;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_pins(input logic [3:0] an, input logic [6:0] pat, input logic dpl);
        {an3, an2, an1, an0} = an;
        {a, b, c, d, e, f, g} = ~pat;
        dp = ~dpl;
    endtask

    // A long enough one-hot hold records the glyph; the fourth distinct position makes a frame.
    task automatic model_capture(input int pos, input logic [6:0] pat, input logic dpl);
        logic [3:0] v = 4'h0;
        logic       er = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if (tbl[i] == pat) begin
                v  = 4'(i);
                er = 1'b0;
            end
        end
        m_val[pos] = v;
        m_dp[pos]  = dpl;
        m_err[pos] = er;
        m_seen[pos] = 1'b1;
        if (m_seen == 4'hF) begin
            exp_q.push_back('{{m_val[3], m_val[2], m_val[1], m_val[0]}, m_dp, m_err});
            m_seen = '0;
        end
    endtask

    task automatic hold(input logic [3:0] an, input logic [6:0] pat, input logic dpl, input int n);
        int pos = 0;
        if (an == cur_an && pat == cur_pat && dpl == cur_dp && $countones(~an) == 1) begin
            drive_pins(4'hF, pat, dpl);
            @(negedge clk);
        end
        drive_pins(an, pat, dpl);
        cur_an = an;
        cur_pat = pat;
        cur_dp = dpl;
        if ($countones(~an) == 1 && n >= S + 4) begin
            for (int i = 0; i < 4; i++) if (an[i] == 1'b0) pos = i;
            model_capture(pos, pat, dpl);
        end
        repeat (n) @(negedge clk);
    endtask

    task automatic cap(input int pos, input int val, input logic dpl, input int n);
        hold(4'(~(4'b0001 << pos)), tbl[val], dpl, n);
    endtask

    task automatic check_outputs(input string tag, input logic [15:0] digs,
                                 input logic [3:0] dps, input logic [3:0] errs);
        check({tag, "_digits"}, {digit3, digit2, digit1, digit0}, digs);
        check({tag, "_dp"}, 16'(dp_out), 16'(dps));
        check({tag, "_err"}, 16'(err_out), 16'(errs));
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (frame_valid === 1'b1) begin
                n_frames++;
                check("frame_expected", 16'(exp_q.size() != 0), 16'd1);
                if (exp_q.size() != 0) begin
                    last_fr = exp_q.pop_front();
                    check("frame_digits", {digit3, digit2, digit1, digit0}, last_fr.digs);
                    check("frame_dp", 16'(dp_out), 16'(last_fr.dps));
                    check("frame_err", 16'(err_out), 16'(last_fr.errs));
                    $display("frame %0d: digits=%h dp=%b err=%b", n_frames,
                             {digit3, digit2, digit1, digit0}, dp_out, err_out);
                end
            end else begin
                check("held_digits", {digit3, digit2, digit1, digit0}, last_fr.digs);
                check("held_dp", 16'(dp_out), 16'(last_fr.dps));
                check("held_err", 16'(err_out), 16'(last_fr.errs));
            end
        end
    end

    initial begin
        int base;
        logic [3:0] an_r;
        logic [6:0] pat_r;

        repeat (5) @(negedge clk);
        reset = 1'b0;
        check_outputs("reset_state", 16'h0, 4'h0, 4'h0);
        check("reset_fv", 16'(frame_valid), 16'd0);
        mon_en = 1'b1;

        // Digits 1,2,3,4 on an0..an3, decimal point on digit2 only.
        cap(0, 1, 1'b0, 200);
        cap(1, 2, 1'b0, 200);
        cap(2, 3, 1'b1, 200);
        cap(3, 4, 1'b0, 200);
        check("frame_1234_count", 16'(n_frames), 16'd1);
        check_outputs("frame_1234", 16'h4321, 4'b0100, 4'b0000);

        // Segment pattern toggling faster than the settle window never captures.
        cap(0, 5, 1'b0, 60);
        cap(1, 6, 1'b0, 60);
        cap(3, 7, 1'b0, 60);
        base = n_frames;
        for (int i = 0; i < 20; i++) cap(2, (i % 2 == 0) ? 8 : 9, 1'b0, 5);
        hold(4'hF, 7'h0, 1'b0, 30);
        check("toggle_no_frame", 16'(n_frames - base), 16'd0);
        cap(2, 10, 1'b1, 60);
        check("toggle_then_frame", 16'(n_frames - base), 16'd1);

        // Two anodes low together is not a digit.
        cap(2, 11, 1'b0, 60);
        cap(3, 12, 1'b0, 60);
        cap(1, 13, 1'b0, 60);
        base = n_frames;
        hold(4'b1100, tbl[14], 1'b0, 300);
        check("dual_low_no_frame", 16'(n_frames - base), 16'd0);
        cap(0, 15, 1'b0, 60);
        check("dual_low_then_frame", 16'(n_frames - base), 16'd1);

        // Unknown glyph on digit1.
        cap(0, 9, 1'b0, 60);
        hold(4'b1101, 7'b1010101, 1'b0, 60);
        cap(2, 10, 1'b0, 60);
        cap(3, 11, 1'b0, 60);
        check_outputs("bad_glyph", 16'hBA09, 4'b0000, 4'b0010);

        // Continuous scan A,b,C,d then F,E,d,C (digit3 first in each list).
        base = n_frames;
        cap(0, 13, 1'b0, 60);
        cap(1, 12, 1'b0, 60);
        cap(2, 11, 1'b0, 60);
        cap(3, 10, 1'b0, 60);
        check_outputs("scan_abcd", 16'hABCD, 4'h0, 4'h0);
        cap(0, 12, 1'b0, 60);
        cap(1, 13, 1'b0, 60);
        cap(2, 14, 1'b0, 60);
        cap(3, 15, 1'b0, 60);
        check_outputs("scan_fedc", 16'hFEDC, 4'h0, 4'h0);
        check("scan_two_frames", 16'(n_frames - base), 16'd2);

        // Reset mid-frame discards the partial captures.
        cap(0, 3, 1'b0, 60);
        cap(1, 4, 1'b1, 60);
        hold(4'hF, 7'h0, 1'b0, 5);
        check("pre_reset_queue", 16'(exp_q.size()), 16'd0);
        #3;
        reset = 1'b1;
        last_fr = '{16'h0, 4'h0, 4'h0};
        m_seen = '0;
        repeat (10) @(negedge clk);
        check_outputs("mid_reset", 16'h0, 4'h0, 4'h0);
        reset = 1'b0;
        base = n_frames;
        cap(2, 5, 1'b0, 60);
        cap(3, 6, 1'b0, 60);
        check("after_reset_partial", 16'(n_frames - base), 16'd0);
        cap(0, 7, 1'b0, 60);
        cap(1, 8, 1'b1, 60);
        check("after_reset_frame", 16'(n_frames - base), 16'd1);
        check_outputs("after_reset", 16'h6587, 4'b0010, 4'b0000);

        // Random strobes, glyphs, decimal points and hold lengths.
        for (int k = 0; k < 80; k++) begin
            an_r = ($urandom_range(0, 9) < 8) ? 4'(~(4'b0001 << $urandom_range(0, 3)))
                                              : 4'($urandom_range(0, 15));
            pat_r = ($urandom_range(0, 4) == 0) ? 7'($urandom) : tbl[$urandom_range(0, 15)];
            hold(an_r, pat_r, 1'($urandom),
                 ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, S - 1))
                                             : int'($urandom_range(S + 4, S + 50)));
        end

        hold(4'hF, 7'h0, 1'b0, 40);
        check("final_queue_drained", 16'(exp_q.size()), 16'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/seven_seg_scan_decoder.md
# seven_seg_scan_decoder

Receive-side counterpart of the four-digit multiplexed LED driver. Watches the active-low anode strobes (an3..an0) and segment lines (a..g, dp), waits for each strobe to settle, and decodes the segment pattern back to a 4-bit hex value. Presents a complete four-digit frame once every digit has been captured. Used as a self-checking monitor beside the driver in simulation, and as a loop-back checker on the board.

## Interface
Parameters:
- STABLE_CYCLES, 16: consecutive identical registered cycles required before a digit is sampled (≥2).
- CNT_W, 8: settle counter width; must hold STABLE_CYCLES-1.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  asynchronous, active-high; clears all state and outputs.
- an3, an2, an1, an0  input  1 each  digit strobes, active-low.
- a, b, c, d, e, f, g, dp  input  1 each  segment lines, active-low.
- digit3, digit2, digit1, digit0  output  4 each  last complete frame, hex value per position.
- dp_out  output  4  decimal-point state per position (bit i = digit i, 1 = lit).
- err_out  output  4  per-position decode error in last frame (pattern not in table).
- frame_valid  output  1  one-cycle pulse when digit*/dp_out/err_out update.

## Operation
- Input stage: all 12 inputs registered once (r_an[3:0], r_seg[6:0] = {a..g} inverted to active-high, r_dp inverted).
- Decode table (active-high {a,b,c,d,e,f,g}): 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011, A=1110111, b=0011111, C=1001110, d=0111101, E=1001111, F=1000111. Any other pattern: value 4'h0, error bit 1.
- FSM states:
  - IDLE: r_an not one-hot-low (all high, or ≥2 low). Counter held 0.
  - SETTLE: exactly one anode low. Counter increments each cycle r_an and r_seg/r_dp equal previous cycle; any change reloads 0 (stays SETTLE if still one-hot-low, else IDLE). Counter reaching STABLE_CYCLES-1 → sample → CAPTURED.
  - CAPTURED: digit held; no re-sampling. Any change of r_an/r_seg/r_dp → SETTLE (counter 0) or IDLE per the one-hot rule.
- Sample: decoded value, dp, error written into the shadow slot of the active position; seen[i] set.
- Frame: when a sample makes seen == 4'b1111, next cycle shadow copied to digit*/dp_out/err_out, frame_valid=1, seen cleared.
- Re-capture of an already-seen position before frame completion overwrites its shadow slot.

## Timing
- Reset values: digit*=0, dp_out=0, err_out=0, frame_valid=0, seen=0, state IDLE, counter 0, input registers 1 (inactive).
- Capture latency: sample taken STABLE_CYCLES+1 clocks after an input change reaches the pins (1 register + STABLE_CYCLES stable cycles).
- frame_valid asserted exactly 1 cycle after the completing sample; outputs stable until the next pulse.
- Glitch shorter than STABLE_CYCLES: no sample, no seen update.
- Segment change while anode unchanged (driver updating value): counter restarts; re-sampled after settling.
- Reset mid-frame: shadow and seen discarded; first frame_valid after reset requires four fresh captures.
- Counter never wraps: saturates in CAPTURED.

## Structure
- Package seven_seg_pkg: decode table constants (SEG_0..SEG_F as 7-bit active-high), decode function, FSM state typedef {IDLE, SETTLE, CAPTURED}; shared with the driver's encoder.
- One sub-module: seg_pattern_decode (combinational 7-bit → {valid, 4-bit value}); everything else in the top.

## Test plan
- Reset asserted 100 ns mid-scan → all outputs 0, no frame_valid until four new captures.
- Drive an0..an3 in turn, 200 cycles each, patterns for 1,2,3,4, dp only on digit2 → one frame_valid; digit3..0=4,3,2,1; dp_out=4'b0100; err_out=0.
- Anode held with segment pattern toggled every 5 cycles (STABLE_CYCLES=16) → no capture, no frame_valid.
- an1 and an0 low together for 300 cycles → stays IDLE, seen unchanged.
- Digit1 pattern 1010101 (not in table), others valid → frame with digit1=0, err_out=4'b0010.
- Continuous driver scan of A,b,C,d followed by F,E,d,C → two consecutive frames with correct values; frame_valid exactly one cycle each.
